// File: rtl/demux1to4_32bit_pkg.sv
// Shared constants and helpers for the 1-to-4 registered demultiplexer.
package demux1to4_32bit_pkg;

    localparam int unsigned DataWDefault = 32;
    localparam int unsigned NumOut       = 4;
    localparam int unsigned SelW         = 2;
    localparam int unsigned CntW         = 3;

    function automatic logic [CntW-1:0] popcnt(input logic [NumOut-1:0] v);
        logic [CntW-1:0] c;
        c = '0;
        for (int i = 0; i < NumOut; i++) begin
            c = c + CntW'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output slot: a single-entry data register with valid flag, load and drain handling.
module demux_slot #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d, data_q;

    // A load wins over a drain, so a same-cycle drain and refill keeps valid set.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux1to4_32bit.sv
// Registered 1-to-4 demultiplexer with per-slot valid/ready handshakes and an occupancy count.
module demux1to4_32bit
    import demux1to4_32bit_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned N_OUT  = NumOut
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [SelW-1:0]   in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [N_OUT-1:0]  out_valid,
    output logic [DATA_W-1:0] out_data_0,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic [DATA_W-1:0] out_data_3,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [CntW-1:0]   full_cnt
);

    logic [N_OUT-1:0]  load;
    logic [DATA_W-1:0] slot_data [N_OUT];
    logic              fill;
    logic [CntW-1:0]   cnt_d, cnt_q;

    // Only the addressed slot decides acceptance; other slots never stall the input.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign fill     = in_valid & in_ready;

    always_comb begin
        load = '0;
        load[in_sel] = fill;
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[k]),
            .data_i  (in_data),
            .ready_i (out_ready[k]),
            .valid_o (out_valid[k]),
            .data_o  (slot_data[k])
        );
    end

    assign out_data_0 = slot_data[0];
    assign out_data_1 = slot_data[1];
    assign out_data_2 = slot_data[2];
    assign out_data_3 = slot_data[3];

    // Several slots can drain in one cycle, so subtract the full drain popcount.
    always_comb begin
        cnt_d = cnt_q + CntW'(fill) - popcnt(out_valid & out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_cnt = cnt_q;

endmodule
